// File: rtl/datapath_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | datapath_mc : multi-cycle datapath (PC, IR, register file) with stallable |
// | instruction/data memory handshakes.                  Revision: 1.0       |
// +--------------------------------------------------------------------------+
module datapath_mc #(
  parameter int WIDTH    = 16,
  parameter int NREGS    = 16,
  parameter int PC_STEP  = 2,
  parameter int RESET_PC = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic [WIDTH-1:0]     instr_addr,
  input  logic [15:0]          instr_rdata,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  output logic [15:0]          ir,
  input  logic [WIDTH/8-1:0]   ctl_reg_byte_en,
  input  logic                 ctl_reg_set,
  input  logic                 ctl_pc_select,
  input  logic                 ctl_mem_read,
  input  logic                 ctl_mem_write,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  input  logic [WIDTH-1:0]     alu_result,
  output logic [WIDTH-1:0]     mem_addr,
  output logic [WIDTH-1:0]     mem_wdata,
  output logic                 mem_read_req,
  output logic                 mem_write_req,
  input  logic                 mem_ready,
  input  logic [WIDTH-1:0]     mem_rdata,
  output logic [WIDTH-1:0]     pc,
  output logic                 retire
);

  localparam int NBYTES = WIDTH / 8;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_MEM   = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [WIDTH-1:0] r_pc;
  logic [15:0]      r_ir;
  logic             r_retire;
  logic [WIDTH-1:0] w_rf [16];
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_pc_inc;
  logic [3:0]       w_x;
  logic [3:0]       w_y;
  logic [3:0]       w_z;
  logic             w_is_mem;
  logic             w_rf_we;
  logic             w_complete;

  assign w_x      = r_ir[11:8];
  assign w_y      = r_ir[7:4];
  assign w_z      = r_ir[3:0];
  assign w_is_mem = ctl_mem_read | ctl_mem_write;
  assign w_pc_inc = r_pc + WIDTH'(PC_STEP);

  // Loads take priority, then the immediate {x,y}, then the ALU.
  assign w_wdata = (r_state == S_MEM) ? mem_rdata :
                   ctl_reg_set        ? {{(WIDTH-8){1'b0}}, r_ir[11:4]} :
                                        alu_result;

  // Unimplemented register slots read as zero and have no storage.
  for (genvar i = 0; i < 16; i++) begin : g_rf
    if (i < NREGS) begin : g_real
      logic [WIDTH-1:0] r_q;
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_q <= '0;
        end else if (w_rf_we && (w_z == 4'(i))) begin
          for (int k = 0; k < NBYTES; k++) begin
            if (ctl_reg_byte_en[k]) r_q[8*k +: 8] <= w_wdata[8*k +: 8];
          end
        end
      end
      assign w_rf[i] = r_q;
    end else begin : g_zero
      assign w_rf[i] = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: if (instr_valid) w_next_state = S_EXEC;
      S_EXEC:  w_next_state = w_is_mem ? S_MEM : S_FETCH;
      S_MEM:   if (mem_ready) w_next_state = S_FETCH;
      default: w_next_state = S_FETCH;
    endcase
  end

  always_comb begin
    instr_ready   = 1'b0;
    mem_read_req  = 1'b0;
    mem_write_req = 1'b0;
    w_rf_we       = 1'b0;
    w_complete    = 1'b0;
    case (r_state)
      S_FETCH: instr_ready = reset;
      S_EXEC: begin
        w_rf_we    = ~w_is_mem;
        w_complete = ~w_is_mem;
      end
      S_MEM: begin
        mem_read_req  = reset & ctl_mem_read;
        mem_write_req = reset & ctl_mem_write & ~ctl_mem_read;
        w_rf_we       = mem_ready & ctl_mem_read;
        w_complete    = mem_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc     <= WIDTH'(RESET_PC);
      r_ir     <= '0;
      r_retire <= 1'b0;
    end else begin
      r_retire <= w_complete;
      if ((r_state == S_FETCH) && instr_valid) r_ir <= instr_rdata;
      if (w_complete) begin
        r_pc <= ((r_state == S_EXEC) && ctl_pc_select) ? w_rf[w_x] : w_pc_inc;
      end
    end
  end

  assign instr_addr = r_pc;
  assign pc         = r_pc;
  assign ir         = r_ir;
  assign retire     = r_retire;
  assign alu_a      = w_rf[w_x];
  assign alu_b      = w_rf[w_y];
  assign mem_addr   = w_rf[w_x];
  assign mem_wdata  = w_rf[w_y];

endmodule
`default_nettype wire

// File: tb/tb_datapath_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_datapath_mc : table, directed and random checks of datapath_mc.       |
// |                                                      Revision: 1.0       |
// +--------------------------------------------------------------------------+
module tb_datapath_mc;

  localparam int WIDTH = 16;
  localparam int NREGS = 12;

  logic        clock;
  logic        reset;
  logic [15:0] instr_addr;
  logic [15:0] instr_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] ir;
  logic [1:0]  ctl_reg_byte_en;
  logic        ctl_reg_set;
  logic        ctl_pc_select;
  logic        ctl_mem_read;
  logic        ctl_mem_write;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_result;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_read_req;
  logic        mem_write_req;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic [15:0] pc;
  logic        retire;

  datapath_mc #(.WIDTH(WIDTH), .NREGS(NREGS), .PC_STEP(2), .RESET_PC(0)) dut (
    .clock(clock), .reset(reset),
    .instr_addr(instr_addr), .instr_rdata(instr_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .ir(ir),
    .ctl_reg_byte_en(ctl_reg_byte_en), .ctl_reg_set(ctl_reg_set),
    .ctl_pc_select(ctl_pc_select), .ctl_mem_read(ctl_mem_read),
    .ctl_mem_write(ctl_mem_write),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .pc(pc), .retire(retire)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Architectural model: register array plus PC.
  logic [15:0] m_regs [16];
  logic [15:0] m_pc;

  typedef struct {
    logic [15:0] instr;
    logic        set;
    logic [1:0]  be;
    logic        psel;
    logic        mrd;
    logic        mwr;
    logic [15:0] alu;
    int          stalls;
    logic [15:0] rdata;
    logic [15:0] exp_a;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rd(input int i);
    return (i < NREGS) ? m_regs[i] : 16'h0000;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                        input logic [1:0] be);
    logic [15:0] r;
    r = old;
    if (be[0]) r[7:0]  = nw[7:0];
    if (be[1]) r[15:8] = nw[15:8];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
    m_pc = 16'h0000;
  endtask

  task automatic rand_ctl();
    ctl_reg_byte_en = 2'($urandom);
    ctl_reg_set     = 1'($urandom);
    ctl_pc_select   = 1'($urandom);
    ctl_mem_read    = 1'($urandom);
    ctl_mem_write   = 1'($urandom);
  endtask

  task automatic do_instr(input logic [15:0] instr, input logic set, input logic [1:0] be,
                          input logic psel, input logic mrd, input logic mwr,
                          input logic [15:0] alu, input int stalls, input logic [15:0] rdata,
                          input int idle, output logic [15:0] a_seen);
    int x, y, z;
    logic [15:0] npc;
    x = int'(instr[11:8]);
    y = int'(instr[7:4]);
    z = int'(instr[3:0]);
    for (int i = 0; i < idle; i++) begin
      @(negedge clock);
      instr_valid = 1'b0; instr_rdata = 16'($urandom); mem_ready = 1'($urandom);
      rand_ctl();
      #1;
      chk("idle_ready", instr_ready, 1);
      chk("idle_pc", pc, m_pc);
      chk("idle_retire", retire, 0);
    end
    @(negedge clock);
    instr_valid = 1'b1; instr_rdata = instr; mem_ready = 1'($urandom);
    rand_ctl();
    #1;
    chk("fetch_ready", instr_ready, 1);
    chk("fetch_addr", instr_addr, m_pc);
    chk("fetch_retire", retire, 0);
    chk("fetch_rdreq", mem_read_req, 0);
    chk("fetch_wrreq", mem_write_req, 0);
    @(negedge clock);
    instr_valid = 1'b0; instr_rdata = 16'($urandom); mem_ready = 1'($urandom);
    ctl_reg_set = set; ctl_reg_byte_en = be; ctl_pc_select = psel;
    ctl_mem_read = mrd; ctl_mem_write = mwr; alu_result = alu;
    #1;
    a_seen = alu_a;
    chk("exec_ir", ir, instr);
    chk("exec_alu_a", alu_a, rd(x));
    chk("exec_alu_b", alu_b, rd(y));
    chk("exec_mem_addr", mem_addr, rd(x));
    chk("exec_mem_wdata", mem_wdata, rd(y));
    chk("exec_ready", instr_ready, 0);
    chk("exec_rdreq", mem_read_req, 0);
    chk("exec_retire", retire, 0);
    if (mrd || mwr) begin
      for (int s = 0; s <= stalls; s++) begin
        @(negedge clock);
        mem_ready = (s == stalls);
        mem_rdata = (s == stalls) ? rdata : 16'($urandom);
        #1;
        chk("mem_rdreq", mem_read_req, mrd);
        chk("mem_wrreq", mem_write_req, mwr & ~mrd);
        chk("mem_pc", pc, m_pc);
        chk("mem_retire", retire, 0);
      end
      if (mrd && z < NREGS) m_regs[z] = merge(m_regs[z], rdata, be);
      m_pc = m_pc + 16'd2;
    end else begin
      npc = psel ? rd(x) : m_pc + 16'd2;
      if (z < NREGS) m_regs[z] = merge(m_regs[z], set ? {8'h00, instr[11:4]} : alu, be);
      m_pc = npc;
    end
    @(negedge clock);
    mem_ready = 1'b0;
    rand_ctl();
    #1;
    chk("retire_pulse", retire, 1);
    chk("retire_pc", pc, m_pc);
    chk("retire_ready", instr_ready, 1);
  endtask

  initial begin
    logic [15:0] a_seen;
    logic [15:0] ri;
    logic        rmem;

    reset = 1'b0; instr_valid = 1'b0; instr_rdata = 16'h0; mem_ready = 1'b0;
    mem_rdata = 16'h0; alu_result = 16'h0;
    rand_ctl();
    model_reset();

    tbl[0]  = '{16'h0A53, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0002};
    tbl[1]  = '{16'h1001, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 16'h1234, 0, 16'h0000, 16'h0000, 16'h0004};
    tbl[2]  = '{16'h2101, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 16'hABCD, 0, 16'h0000, 16'h1234, 16'h0006};
    tbl[3]  = '{16'h3102, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0100, 0, 16'h0000, 16'hAB34, 16'h0008};
    tbl[4]  = '{16'h4204, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 16'h0000, 3, 16'hBEEF, 16'h0100, 16'h000A};
    tbl[5]  = '{16'h5407, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 16'hFFFE, 0, 16'h0000, 16'hBEEF, 16'h000C};
    tbl[6]  = '{16'h6700, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 16'h0000, 16'hFFFE, 16'hFFFE};
    tbl[7]  = '{16'h7300, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 16'h0000, 16'h00A5, 16'h0000};
    tbl[8]  = '{16'h8D0D, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 16'h5555, 0, 16'h0000, 16'h0000, 16'h0002};
    tbl[9]  = '{16'h9D00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0004};
    tbl[10] = '{16'hA132, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 16'h0000, 0, 16'h7777, 16'hAB34, 16'h0006};
    tbl[11] = '{16'hB200, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 16'h0000, 16'h0100, 16'h0008};
    tbl[12] = '{16'hC441, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 16'h0000, 1, 16'h1111, 16'hBEEF, 16'h000A};
    tbl[13] = '{16'hD100, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 16'h0000, 16'hAB11, 16'h000C};

    // Reset held with random activity on every input.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      instr_valid = 1'($urandom); instr_rdata = 16'($urandom); mem_ready = 1'($urandom);
      mem_rdata = 16'($urandom); alu_result = 16'($urandom);
      rand_ctl();
      #1;
      chk("rst_pc", pc, 16'h0000);
      chk("rst_ir", ir, 16'h0000);
      chk("rst_ready", instr_ready, 0);
      chk("rst_rdreq", mem_read_req, 0);
      chk("rst_wrreq", mem_write_req, 0);
      chk("rst_retire", retire, 0);
    end
    @(negedge clock);
    reset = 1'b1; instr_valid = 1'b0;
    #1;
    chk("rel_ready", instr_ready, 1);

    for (int i = 0; i < 14; i++) begin
      do_instr(tbl[i].instr, tbl[i].set, tbl[i].be, tbl[i].psel, tbl[i].mrd, tbl[i].mwr,
               tbl[i].alu, tbl[i].stalls, tbl[i].rdata, i % 2, a_seen);
      chk("tbl_alu_a", a_seen, tbl[i].exp_a);
      chk("tbl_pc", pc, tbl[i].exp_pc);
    end

    // Reset while a store is stalled in MEM.
    @(negedge clock);
    instr_valid = 1'b1; instr_rdata = 16'hE5A1;
    @(negedge clock);
    instr_valid = 1'b0; ctl_mem_write = 1'b1; ctl_mem_read = 1'b0;
    ctl_reg_set = 1'b0; ctl_pc_select = 1'b0; ctl_reg_byte_en = 2'b11;
    @(negedge clock);
    mem_ready = 1'b0;
    #1;
    chk("midmem_wrreq_on", mem_write_req, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("midmem_wrreq_off", mem_write_req, 0);
    chk("midmem_pc", pc, 16'h0000);
    chk("midmem_ready", instr_ready, 0);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    do_instr(16'h1400, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 16'h0000, 0, a_seen);
    chk("after_rst_r4", a_seen, 16'h0000);
    chk("after_rst_pc", pc, 16'h0002);

    // Random instruction stream against the model.
    for (int n = 0; n < 80; n++) begin
      ri   = 16'($urandom);
      rmem = ($urandom_range(0, 2) == 0);
      do_instr(ri, 1'($urandom), 2'($urandom), ($urandom_range(0, 5) == 0),
               rmem & 1'($urandom), rmem & 1'($urandom) | (rmem & ($urandom_range(0, 1) == 0)),
               16'($urandom), $urandom_range(0, 3), 16'($urandom), $urandom_range(0, 2), a_seen);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
